// File: rtl/mem_port_arbiter_if.sv
// Bundle of the IF request/response, MEM request/response and memory-port signals
// around mem_port_arbiter; master is the arbiter's view, slave the requesters' and memory's.
interface mem_port_arbiter_if;
   logic        imReq;
   logic [31:0] imAddr;
   logic        imGnt;
   logic        imRvalid;
   logic [31:0] imRdata;

   logic        dmReq;
   logic        dmWe;
   logic [31:0] dmAddr;
   logic [31:0] dmWdata;
   logic [3:0]  dmBe;
   logic        dmGnt;
   logic        dmRvalid;
   logic [31:0] dmRdata;

   logic        memReq;
   logic        memWe;
   logic [31:0] memAddr;
   logic [31:0] memWdata;
   logic [3:0]  memBe;
   logic        memGnt;
   logic        memRvalid;
   logic [31:0] memRdata;

   logic        errRsp;

   modport master (
      input  imReq, imAddr, dmReq, dmWe, dmAddr, dmWdata, dmBe,
      input  memGnt, memRvalid, memRdata,
      output imGnt, imRvalid, imRdata, dmGnt, dmRvalid, dmRdata,
      output memReq, memWe, memAddr, memWdata, memBe, errRsp
   );

   modport slave (
      output imReq, imAddr, dmReq, dmWe, dmAddr, dmWdata, dmBe,
      output memGnt, memRvalid, memRdata,
      input  imGnt, imRvalid, imRdata, dmGnt, dmRvalid, dmRdata,
      input  memReq, memWe, memAddr, memWdata, memBe, errRsp
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and MEM-stage data access: one
// transaction outstanding, responses routed to their owner, bounded starvation and latency.
module mem_port_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned RSP_TIMEOUT  = 16
) (
   input  logic               clk,
   input  logic               rst,
   mem_port_arbiter_if.master bus
);

   localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
   localparam int unsigned TW = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT) : 1;
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
   localparam logic [TW-1:0] TO_LAST    = TW'(RSP_TIMEOUT - 1);

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_WAIT_RSP = 1'b1} state_e;
   typedef enum logic [0:0] {OWN_IM = 1'b0, OWN_DM = 1'b1} owner_e;

   state_e        state_r;
   state_e        state_nxt_s;
   owner_e        owner_r;
   owner_e        owner_nxt_s;
   logic [TW-1:0] to_cnt_r;
   logic [TW-1:0] to_cnt_nxt_s;
   logic [SW-1:0] starve_cnt_r;
   logic [SW-1:0] starve_cnt_nxt_s;

   logic rsp_s;
   logic timeout_s;
   logic arb_en_s;
   logic sel_im_s;
   logic sel_dm_s;
   logic issue_s;
   logic take_s;
   logic im_gnt_s;
   logic dm_gnt_s;

   // A response or a new arbitration can only happen with the port free or freeing this cycle.
   assign rsp_s     = (state_r == ST_WAIT_RSP) && bus.memRvalid;
   assign timeout_s = (state_r == ST_WAIT_RSP) && !bus.memRvalid && (to_cnt_r == TO_LAST);
   assign arb_en_s  = (state_r == ST_IDLE) || rsp_s;
   assign sel_im_s  = bus.imReq && (!bus.dmReq || (starve_cnt_r == STARVE_MAX));
   assign sel_dm_s  = bus.dmReq && !sel_im_s;
   assign issue_s   = arb_en_s && (bus.imReq || bus.dmReq);
   assign take_s    = issue_s && bus.memGnt;
   assign im_gnt_s  = take_s && sel_im_s;
   assign dm_gnt_s  = take_s && sel_dm_s;

   // Next-state logic for the transaction tracker.
   always_comb begin
      state_nxt_s  = state_r;
      owner_nxt_s  = owner_r;
      to_cnt_nxt_s = to_cnt_r;
      case (state_r)
         ST_IDLE: begin
            if (take_s) begin
               state_nxt_s  = ST_WAIT_RSP;
               owner_nxt_s  = sel_im_s ? OWN_IM : OWN_DM;
               to_cnt_nxt_s = {TW{1'b0}};
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_WAIT_RSP: begin
            if (take_s) begin
               state_nxt_s  = ST_WAIT_RSP;
               owner_nxt_s  = sel_im_s ? OWN_IM : OWN_DM;
               to_cnt_nxt_s = {TW{1'b0}};
            end else if (rsp_s || timeout_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               to_cnt_nxt_s = to_cnt_r + TW'(1);
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Each cycle IF loses to a DM grant counts towards forcing an IF win.
   always_comb begin
      starve_cnt_nxt_s = starve_cnt_r;
      if (im_gnt_s) begin
         starve_cnt_nxt_s = {SW{1'b0}};
      end else if (bus.imReq && dm_gnt_s && (starve_cnt_r != STARVE_MAX)) begin
         starve_cnt_nxt_s = starve_cnt_r + SW'(1);
      end else begin
         starve_cnt_nxt_s = starve_cnt_r;
      end
   end

   // State, owner and counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         owner_r      <= OWN_DM;
         to_cnt_r     <= {TW{1'b0}};
         starve_cnt_r <= {SW{1'b0}};
      end else begin
         state_r      <= state_nxt_s;
         owner_r      <= owner_nxt_s;
         to_cnt_r     <= to_cnt_nxt_s;
         starve_cnt_r <= starve_cnt_nxt_s;
      end
   end

   // Output muxing; grant and response paths stay combinational, everything is zero under reset.
   always_comb begin
      bus.memReq   = 1'b0;
      bus.memWe    = 1'b0;
      bus.memAddr  = 32'h0000_0000;
      bus.memWdata = 32'h0000_0000;
      bus.memBe    = 4'b0000;
      bus.imGnt    = 1'b0;
      bus.dmGnt    = 1'b0;
      bus.imRvalid = 1'b0;
      bus.dmRvalid = 1'b0;
      bus.imRdata  = 32'h0000_0000;
      bus.dmRdata  = 32'h0000_0000;
      bus.errRsp   = 1'b0;
      if (!rst) begin
         bus.memReq = issue_s;
         if (issue_s && sel_im_s) begin
            bus.memAddr = bus.imAddr;
            bus.memBe   = 4'b1111;
         end else if (issue_s && sel_dm_s) begin
            bus.memWe    = bus.dmWe;
            bus.memAddr  = bus.dmAddr;
            bus.memWdata = bus.dmWdata;
            bus.memBe    = bus.dmBe;
         end else begin
            bus.memWe = 1'b0;
         end
         bus.imGnt    = im_gnt_s;
         bus.dmGnt    = dm_gnt_s;
         bus.imRvalid = (rsp_s || timeout_s) && (owner_r == OWN_IM);
         bus.dmRvalid = (rsp_s || timeout_s) && (owner_r == OWN_DM);
         bus.imRdata  = timeout_s ? 32'h0000_0000 : bus.memRdata;
         bus.dmRdata  = timeout_s ? 32'h0000_0000 : bus.memRdata;
         bus.errRsp   = timeout_s;
      end else begin
         bus.memReq = 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter; a transaction-level model of the
// shared port predicts every output each cycle.
module tb_mem_port_arbiter;
   localparam int SL = 4;
   localparam int TO = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_port_arbiter_if bus ();

   mem_port_arbiter #(.STARVE_LIMIT(SL), .RSP_TIMEOUT(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // transaction-level model: is the port busy, who owns it, how old it is, IF losses
   bit m_busy   = 1'b0;
   bit m_own_im = 1'b0;
   int m_age    = 0;
   int m_starve = 0;
   bit e_img    = 1'b0;
   bit e_dmg    = 1'b0;
   bit e_accept = 1'b0;

   logic        o_img, o_dmg, o_imrv, o_dmrv, o_err;
   logic [31:0] o_imrd, o_dmrd;

   bit pend = 1'b0;
   int due  = 0;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b cycle=%0d", tag, obs, exp, cyc);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
      end
   endtask

   task automatic clear_inputs();
      bus.imReq = 1'b0; bus.imAddr = 32'h0;
      bus.dmReq = 1'b0; bus.dmWe = 1'b0; bus.dmAddr = 32'h0; bus.dmWdata = 32'h0; bus.dmBe = 4'h0;
      bus.memGnt = 1'b0; bus.memRvalid = 1'b0; bus.memRdata = 32'h0;
   endtask

   // Check the current cycle against the model, advance the model, then move past the next edge.
   task automatic tick();
      bit resp, tmo, issue, imw, ereq;
      #1;
      if (rst) begin
         chk1("rst_memReq", bus.memReq, 1'b0);
         chk1("rst_imGnt", bus.imGnt, 1'b0);
         chk1("rst_dmGnt", bus.dmGnt, 1'b0);
         chk1("rst_imRvalid", bus.imRvalid, 1'b0);
         chk1("rst_dmRvalid", bus.dmRvalid, 1'b0);
         chk1("rst_errRsp", bus.errRsp, 1'b0);
         chk1("rst_memWe", bus.memWe, 1'b0);
         chk32("rst_memAddr", bus.memAddr, 32'h0);
         chk32("rst_memWdata", bus.memWdata, 32'h0);
         chk32("rst_memBe", 32'(bus.memBe), 32'h0);
         chk32("rst_imRdata", bus.imRdata, 32'h0);
         chk32("rst_dmRdata", bus.dmRdata, 32'h0);
         m_busy = 1'b0; m_age = 0; m_starve = 0;
         e_img = 1'b0; e_dmg = 1'b0; e_accept = 1'b0;
      end else begin
         resp  = m_busy && bus.memRvalid;
         tmo   = m_busy && !bus.memRvalid && (m_age == TO);
         issue = !m_busy || resp;
         imw   = bus.imReq && (!bus.dmReq || (m_starve == SL));
         ereq  = issue && (bus.imReq || bus.dmReq);
         e_img = ereq && imw && bus.memGnt;
         e_dmg = ereq && !imw && bus.memGnt;
         e_accept = e_img || e_dmg;
         chk1("memReq", bus.memReq, ereq);
         chk1("imGnt", bus.imGnt, e_img);
         chk1("dmGnt", bus.dmGnt, e_dmg);
         chk1("imRvalid", bus.imRvalid, (resp || tmo) && m_own_im);
         chk1("dmRvalid", bus.dmRvalid, (resp || tmo) && !m_own_im);
         chk1("errRsp", bus.errRsp, tmo);
         if (ereq && imw) begin
            chk1("im_memWe", bus.memWe, 1'b0);
            chk32("im_memAddr", bus.memAddr, bus.imAddr);
            chk32("im_memWdata", bus.memWdata, 32'h0);
            chk32("im_memBe", 32'(bus.memBe), 32'hF);
         end else if (ereq) begin
            chk1("dm_memWe", bus.memWe, bus.dmWe);
            chk32("dm_memAddr", bus.memAddr, bus.dmAddr);
            chk32("dm_memWdata", bus.memWdata, bus.dmWdata);
            chk32("dm_memBe", 32'(bus.memBe), 32'(bus.dmBe));
         end
         if (tmo) begin
            chk32("to_rdata", m_own_im ? bus.imRdata : bus.dmRdata, 32'h0);
         end else begin
            chk32("imRdata", bus.imRdata, bus.memRdata);
            chk32("dmRdata", bus.dmRdata, bus.memRdata);
         end
         if (e_accept) begin
            m_busy = 1'b1; m_own_im = e_img; m_age = 1;
         end else if (resp || tmo) begin
            m_busy = 1'b0;
         end else if (m_busy) begin
            m_age++;
         end
         if (e_img) m_starve = 0;
         else if (bus.imReq && e_dmg && m_starve < SL) m_starve++;
      end
      o_img = bus.imGnt; o_dmg = bus.dmGnt; o_imrv = bus.imRvalid; o_dmrv = bus.dmRvalid;
      o_err = bus.errRsp; o_imrd = bus.imRdata; o_dmrd = bus.dmRdata;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      clear_inputs();
      @(posedge clk);
      #1;

      // reset with busy-looking inputs
      rst = 1'b1; bus.imReq = 1'b1; bus.dmReq = 1'b1; bus.memGnt = 1'b1; bus.memRvalid = 1'b1;
      bus.memRdata = 32'hA5A5_A5A5; bus.dmWe = 1'b1; bus.dmBe = 4'hF; bus.dmAddr = 32'h44;
      tick(); tick();
      rst = 1'b0; clear_inputs();
      tick();

      // single IF read
      bus.imReq = 1'b1; bus.imAddr = 32'h100; bus.memGnt = 1'b1;
      tick(); chk1("tp_if_gnt", o_img, 1'b1);
      bus.imReq = 1'b0; bus.memGnt = 1'b0;
      tick(); chk1("tp_if_early_rv", o_imrv, 1'b0);
      bus.memRvalid = 1'b1; bus.memRdata = 32'hDEAD_BEEF;
      tick(); chk1("tp_if_rv", o_imrv, 1'b1); chk32("tp_if_rdata", o_imrd, 32'hDEAD_BEEF);
      chk1("tp_if_dmrv", o_dmrv, 1'b0);
      bus.memRvalid = 1'b0;
      tick();

      // store
      bus.dmReq = 1'b1; bus.dmWe = 1'b1; bus.dmBe = 4'b0011; bus.dmWdata = 32'h1234;
      bus.dmAddr = 32'h200; bus.memGnt = 1'b1;
      tick(); chk1("tp_st_gnt", o_dmg, 1'b1);
      bus.dmReq = 1'b0; bus.memGnt = 1'b0; bus.memRvalid = 1'b1; bus.memRdata = 32'h0;
      tick(); chk1("tp_st_ack", o_dmrv, 1'b1);
      bus.memRvalid = 1'b0; bus.dmWe = 1'b0;

      // back-to-back: DM response and IF grant in the same cycle
      bus.dmReq = 1'b1; bus.dmAddr = 32'h300; bus.dmBe = 4'hF; bus.memGnt = 1'b1;
      tick();
      bus.dmReq = 1'b0; bus.imReq = 1'b1; bus.imAddr = 32'h400;
      bus.memRvalid = 1'b1; bus.memRdata = 32'h5555_0001;
      tick(); chk1("tp_b2b_dmrv", o_dmrv, 1'b1); chk1("tp_b2b_img", o_img, 1'b1);
      bus.imReq = 1'b0; bus.memGnt = 1'b0; bus.memRdata = 32'h6666_0002;
      tick(); chk1("tp_b2b_imrv", o_imrv, 1'b1); chk32("tp_b2b_imrd", o_imrd, 32'h6666_0002);
      bus.memRvalid = 1'b0;

      // timeout: 16 cycles after the grant edge
      bus.imReq = 1'b1; bus.imAddr = 32'h500; bus.memGnt = 1'b1; bus.memRdata = 32'hCAFE_F00D;
      tick();
      bus.imReq = 1'b0; bus.memGnt = 1'b0;
      for (int k = 1; k < TO; k++) begin
         tick(); chk1("tp_to_early", o_err, 1'b0);
      end
      tick(); chk1("tp_to_err", o_err, 1'b1); chk1("tp_to_rv", o_imrv, 1'b1);
      chk32("tp_to_rdata", o_imrd, 32'h0);
      bus.memRvalid = 1'b1;
      tick(); chk1("tp_stray_rv", o_imrv, 1'b0); chk1("tp_stray_err", o_err, 1'b0);
      bus.memRvalid = 1'b0;

      // starvation: DM four times, then IF, repeating
      rst = 1'b1; tick(); rst = 1'b0;
      bus.imReq = 1'b1; bus.dmReq = 1'b1; bus.memGnt = 1'b1; bus.memRvalid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         chk1("tp_starve_im", o_img, (k % 5) == 4);
         chk1("tp_starve_dm", o_dmg, (k % 5) != 4);
      end
      clear_inputs(); bus.memRvalid = 1'b1;
      tick();
      bus.memRvalid = 1'b0;

      // reset while a transaction is outstanding
      bus.dmReq = 1'b1; bus.dmAddr = 32'h600; bus.memGnt = 1'b1;
      tick();
      bus.dmReq = 1'b0; bus.memGnt = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0; bus.memRvalid = 1'b1; bus.memRdata = 32'h7777_0003;
      tick(); chk1("tp_rst_norsp", o_dmrv, 1'b0);
      bus.memRvalid = 1'b0; bus.imReq = 1'b1; bus.imAddr = 32'h700; bus.memGnt = 1'b1;
      tick(); chk1("tp_rst_gnt", o_img, 1'b1);
      bus.imReq = 1'b0; bus.memGnt = 1'b0; bus.memRvalid = 1'b1;
      tick(); chk1("tp_rst_rv", o_imrv, 1'b1);
      clear_inputs();

      // randomized traffic with a well-behaved memory
      pend = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 299) == 0);
         if (rst) pend = 1'b0;
         if (!bus.imReq || e_img) begin
            bus.imReq = 1'($urandom_range(0, 1)); bus.imAddr = $urandom;
         end
         if (!bus.dmReq || e_dmg) begin
            bus.dmReq = 1'($urandom_range(0, 1)); bus.dmWe = 1'($urandom_range(0, 1));
            bus.dmAddr = $urandom; bus.dmWdata = $urandom; bus.dmBe = 4'($urandom_range(0, 15));
         end
         bus.memGnt = ($urandom_range(0, 3) != 0);
         bus.memRdata = $urandom;
         if (pend && (due == cyc)) begin
            bus.memRvalid = 1'b1; pend = 1'b0;
         end else begin
            bus.memRvalid = !m_busy && ($urandom_range(0, 7) == 0);
         end
         tick();
         if (e_accept) begin
            if ($urandom_range(0, 15) == 0) begin
               pend = 1'b0;
            end else begin
               pend = 1'b1; due = cyc + $urandom_range(1, 4) - 1;
            end
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer for the single shared memory port used by instruction fetch (IF) and the data-memory access of the MEM stage. It grants one requester at a time, tracks the single outstanding transaction, routes the response back to its owner, and bounds fetch starvation and memory response latency. It sits between the IF/MEM stage request logic and the memory subsystem. `dmLoadData` seen by the MEM/WB stage is this block's `dmRdata`.

## Interface
- `STARVE_LIMIT`, default 4: consecutive lost arbitrations after which IF wins the next one.
- `RSP_TIMEOUT`, default 16: cycles in WAIT_RSP without `memRvalid` before a forced error completion.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `imReq` in 1: IF request; held with `imAddr` stable until `imGnt`.
- `imAddr` in 32: IF word address.
- `imGnt` out 1: IF request accepted this cycle.
- `imRvalid` out 1: IF response valid.
- `imRdata` out 32: IF response data.
- `dmReq` in 1: MEM request; held with all `dm*` stable until `dmGnt`.
- `dmWe` in 1: 1 = store, 0 = load.
- `dmAddr` in 32: data address.
- `dmWdata` in 32: store data.
- `dmBe` in 4: byte enables.
- `dmGnt` out 1: MEM request accepted this cycle.
- `dmRvalid` out 1: MEM response valid (load data or store ack).
- `dmRdata` out 32: MEM response data.
- `memReq` out 1: request to memory.
- `memWe` out 1: write.
- `memAddr` out 32: address.
- `memWdata` out 32: write data.
- `memBe` out 4: byte enables (4'b1111 for IF).
- `memGnt` in 1: memory accepts `memReq` this cycle.
- `memRvalid` in 1: exactly one per accepted request, no earlier than the cycle after `memGnt`.
- `memRdata` in 32: response data.
- `errRsp` out 1: one-cycle pulse on timeout completion.

## Operation
- FSM states:
  - IDLE: no transaction outstanding.
  - WAIT_RSP: one transaction outstanding; `owner` register holds IM or DM.
- Arbitration, evaluated in IDLE, or in WAIT_RSP in the cycle `memRvalid` arrives:
  - Only one of `imReq`/`dmReq` set: that requester is selected.
  - Both set: DM wins, unless `starveCnt == STARVE_LIMIT`, in which case IM wins.
- Request path:
  - `memReq` = any selected request.
  - `mem*` fields are muxed from the selected requester.
  - IM drives `memWe=0`, `memWdata=0`, `memBe=4'b1111`.
- Grant: selected requester's gnt = `memGnt`; the other gnt = 0.
- On `memGnt`: `owner` <= selected, state <= WAIT_RSP, `toCnt` <= 0.
- WAIT_RSP with no `memRvalid`:
  - `memReq=0`; no grants.
  - `toCnt` increments.
- WAIT_RSP with `memRvalid`:
  - Owner's rvalid = 1; owner's rdata = `memRdata`.
  - Back-to-back: a new arbitration/issue is allowed in the same cycle.
  - State stays WAIT_RSP if the new request is granted, else goes to IDLE.
- Timeout: when `toCnt == RSP_TIMEOUT-1` and no `memRvalid`:
  - Owner rvalid = 1, rdata = 32'h0, `errRsp` = 1.
  - State -> IDLE; no new issue that cycle.
  - `memRvalid` arriving in IDLE is ignored.
- `starveCnt` (width `$clog2(STARVE_LIMIT+1)`):
  - Increments, saturating at `STARVE_LIMIT`, in each cycle `imReq` and `dmGnt` are both 1.
  - Clears on `imGnt`.
- Non-owner rvalid is always 0. Both rdata outputs carry `memRdata` when not timing out.

## Timing
- Reset (`rst`=1 at a clock edge), synchronous:
  - state=IDLE, `owner`=DM, `toCnt`=0, `starveCnt`=0.
  - While `rst` is high, all outputs are forced to 0: `memReq`, `imGnt`, `dmGnt`, `imRvalid`, `dmRvalid`, `errRsp`, `memWe`, `memAddr`, `memWdata`, `memBe`, `imRdata`, `dmRdata`.
- Reset mid-transaction drops the outstanding transaction; no rvalid is produced for it.
- Grant latency: combinational, same cycle as `memGnt`.
- Response latency: combinational, same cycle as `memRvalid`.
- Minimum spacing: one transaction per cycle with back-to-back responses; a response must come one or more cycles after its grant.
- Timeout completion occurs exactly `RSP_TIMEOUT` cycles after the grant edge.

## Test plan
- Single IF read: `imReq`, `imAddr`=0x100, `memGnt` in cycle 0, `memRvalid` with 0xDEADBEEF in cycle 2 -> `imGnt` in cycle 0; `imRvalid`, `imRdata`=0xDEADBEEF in cycle 2; `dmRvalid`=0 throughout.
- Simultaneous requests, memory always granting with 1-cycle responses, both requests held continuously -> DM granted 4 times, then IM once; pattern repeats; `starveCnt` clears after the IM grant.
- Store: `dmWe`=1, `dmBe`=4'b0011, `dmWdata`=0x1234 -> `memWe`=1, `memBe`=4'b0011, `memWdata`=0x1234; the ack returns on `dmRvalid`.
- Back-to-back: response for a DM load arrives in the same cycle as a pending `imReq` with `memGnt` -> `dmRvalid`=1 and `imGnt`=1 in that cycle; state stays WAIT_RSP with owner IM.
- Timeout: grant with no `memRvalid` for 16 cycles -> owner rvalid=1, rdata=0, `errRsp`=1 for exactly one cycle, 16 cycles after the grant edge; a later `memRvalid` in IDLE produces no rvalid.
- `rst` asserted while in WAIT_RSP -> all outputs 0 from the next edge; no response delivered; normal operation after `rst` deasserts.
